// File: rtl/stereo_pkg.sv
// Shared types and defaults for the stereo disparity front end.
package stereo_pkg;
    localparam int KERNEL_WIDTH   = 3;
    localparam int DEFAULT_WIDTH  = 320;
    localparam int DEFAULT_HEIGHT = 180;

    typedef logic [7:0] pixel_t;
    typedef pixel_t [KERNEL_WIDTH-1:0] column_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ISSUE
    } fetch_state_t;
endpackage

// File: rtl/stereo_column_fetch_tag_pipe.sv
// Valid+tag delay line matching BRAM read latency; decodes the returning
// tag into a one-hot write enable for the column element it belongs to.
module tag_pipe #(
    parameter int DEPTH    = 2,
    parameter int NUM_TAGS = 3,
    parameter int TAG_W    = 2
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                vld_in,
    input  logic [TAG_W-1:0]    tag_in,
    output logic [NUM_TAGS-1:0] we_out
);
    logic [DEPTH-1:0]            vld_pipe_q, vld_pipe_d;
    logic [DEPTH-1:0][TAG_W-1:0] tag_pipe_q, tag_pipe_d;

    always_comb begin
        vld_pipe_d    = vld_pipe_q << 1;
        vld_pipe_d[0] = vld_in;
        tag_pipe_d    = tag_pipe_q << TAG_W;
        tag_pipe_d[0] = tag_in;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            vld_pipe_q <= '0;
            tag_pipe_q <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            tag_pipe_q <= tag_pipe_d;
        end
    end

    always_comb begin
        we_out = '0;
        for (int k = 0; k < NUM_TAGS; k++) begin
            if (vld_pipe_q[DEPTH-1] && tag_pipe_q[DEPTH-1] == TAG_W'(k))
                we_out[k] = 1'b1;
        end
    end
endmodule

// File: rtl/stereo_column_fetch.sv
// Scans a stored stereo frame pair and hands 3-pixel vertical columns to the
// sad stage, one column position at a time, gated by sad's busy flag.
module stereo_column_fetch
    import stereo_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int HEIGHT       = DEFAULT_HEIGHT,
    parameter int KERNEL_WIDTH = stereo_pkg::KERNEL_WIDTH,
    parameter int BRAM_LATENCY = 2,
    parameter int ADDR_W       = $clog2(WIDTH*HEIGHT)
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         start_in,
    input  logic                         sad_busy_in,
    output logic [ADDR_W-1:0]            left_addr_out,
    output logic [ADDR_W-1:0]            right_addr_out,
    input  logic [7:0]                   left_pixel_in,
    input  logic [7:0]                   right_pixel_in,
    output logic [KERNEL_WIDTH-1:0][7:0] left_data_out,
    output logic [KERNEL_WIDTH-1:0][7:0] right_data_out,
    output logic [10:0]                  hcount_out,
    output logic [9:0]                   vcount_out,
    output logic                         data_valid_out,
    output logic                         busy_out,
    output logic                         done_out
);
    localparam int TAG_W = 2;
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(WIDTH);
    localparam logic [10:0]       X_LAST   = 11'(WIDTH - 1);
    localparam logic [9:0]        Y_LAST   = 10'(HEIGHT - 2);
    localparam logic [TAG_W-1:0]  K_LAST   = TAG_W'(KERNEL_WIDTH - 1);

    fetch_state_t                 state_q, state_d;
    logic [TAG_W-1:0]             k_q, k_d;
    logic [10:0]                  x_q, x_d;
    logic [9:0]                   y_q, y_d;
    logic [ADDR_W-1:0]            row_base_q, row_base_d;
    logic [ADDR_W-1:0]            addr_q, addr_d;
    pixel_t [KERNEL_WIDTH-1:0]    left_col_q, left_col_d;
    pixel_t [KERNEL_WIDTH-1:0]    right_col_q, right_col_d;
    logic                         done_q, done_d;
    logic                         issue_fire;
    logic [KERNEL_WIDTH-1:0]      cap_we;

    tag_pipe #(
        .DEPTH    (BRAM_LATENCY),
        .NUM_TAGS (KERNEL_WIDTH),
        .TAG_W    (TAG_W)
    ) u_tag_pipe (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .vld_in (state_q == S_FETCH),
        .tag_in (k_q),
        .we_out (cap_we)
    );

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        x_d         = x_q;
        y_d         = y_q;
        row_base_d  = row_base_q;
        addr_d      = addr_q;
        left_col_d  = left_col_q;
        right_col_d = right_col_q;
        done_d      = 1'b0;
        issue_fire  = 1'b0;

        // Capture is independent of state: with short latencies data returns mid-FETCH.
        for (int k = 0; k < KERNEL_WIDTH; k++) begin
            if (cap_we[k]) begin
                left_col_d[k]  = left_pixel_in;
                right_col_d[k] = right_pixel_in;
            end
        end

        case (state_q)
            S_IDLE: begin
                // done_q marks the cycle right after the last column; starts are dropped there.
                if (start_in && !done_q) begin
                    state_d    = S_FETCH;
                    k_d        = '0;
                    x_d        = '0;
                    y_d        = 10'd1;
                    row_base_d = '0;
                    addr_d     = '0;
                end
            end
            S_FETCH: begin
                if (k_q == K_LAST) begin
                    state_d = S_WAIT;
                end else begin
                    k_d    = k_q + TAG_W'(1);
                    addr_d = addr_q + ROW_STEP;
                end
            end
            S_WAIT: begin
                if (cap_we[KERNEL_WIDTH-1]) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (!sad_busy_in) begin
                    issue_fire = 1'b1;
                    k_d        = '0;
                    if (x_q != X_LAST) begin
                        x_d     = x_q + 11'd1;
                        addr_d  = row_base_q + ADDR_W'(x_q) + ADDR_W'(1);
                        state_d = S_FETCH;
                    end else if (y_q != Y_LAST) begin
                        x_d        = '0;
                        y_d        = y_q + 10'd1;
                        row_base_d = row_base_q + ROW_STEP;
                        addr_d     = row_base_q + ROW_STEP;
                        state_d    = S_FETCH;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            x_q         <= '0;
            y_q         <= '0;
            row_base_q  <= '0;
            addr_q      <= '0;
            left_col_q  <= '0;
            right_col_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            x_q         <= x_d;
            y_q         <= y_d;
            row_base_q  <= row_base_d;
            addr_q      <= addr_d;
            left_col_q  <= left_col_d;
            right_col_q <= right_col_d;
            done_q      <= done_d;
        end
    end

    assign left_addr_out  = addr_q;
    assign right_addr_out = addr_q;
    assign left_data_out  = left_col_q;
    assign right_data_out = right_col_q;
    assign hcount_out     = x_q;
    assign vcount_out     = y_q;
    assign data_valid_out = issue_fire;
    assign busy_out       = (state_q != S_IDLE);
    assign done_out       = done_q;
endmodule

// File: tb/tb_stereo_column_fetch.sv
// Self-checking bench for stereo_column_fetch on an 8x4 frame with a 2-cycle BRAM model.
module tb_stereo_column_fetch;
    localparam int W    = 8;
    localparam int H    = 4;
    localparam int L    = 2;
    localparam int AW   = $clog2(W*H);
    localparam int NCOL = W*(H-2);

    logic                clk_in = 1'b0;
    logic                rst_in = 1'b1;
    logic                start_in = 1'b0;
    logic                sad_busy_in = 1'b0;
    logic [AW-1:0]       left_addr_out, right_addr_out;
    logic [7:0]          left_pixel_in, right_pixel_in;
    logic [2:0][7:0]     left_data_out, right_data_out;
    logic [10:0]         hcount_out;
    logic [9:0]          vcount_out;
    logic                data_valid_out, busy_out, done_out;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]      lmem [W*H];
    logic [7:0]      rmem [W*H];
    logic [7:0]      lp1, lp2, rp1, rp2;
    logic [2:0][7:0] exp_l [NCOL];
    logic [2:0][7:0] exp_r [NCOL];
    int              exp_x [NCOL];
    int              exp_y [NCOL];

    always #5 clk_in = ~clk_in;

    stereo_column_fetch #(
        .WIDTH        (W),
        .HEIGHT       (H),
        .KERNEL_WIDTH (3),
        .BRAM_LATENCY (L),
        .ADDR_W       (AW)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .start_in       (start_in),
        .sad_busy_in    (sad_busy_in),
        .left_addr_out  (left_addr_out),
        .right_addr_out (right_addr_out),
        .left_pixel_in  (left_pixel_in),
        .right_pixel_in (right_pixel_in),
        .left_data_out  (left_data_out),
        .right_data_out (right_data_out),
        .hcount_out     (hcount_out),
        .vcount_out     (vcount_out),
        .data_valid_out (data_valid_out),
        .busy_out       (busy_out),
        .done_out       (done_out)
    );

    // Two-stage registered read, matching BRAM_LATENCY = 2.
    always @(posedge clk_in) begin
        lp1 <= lmem[left_addr_out];
        lp2 <= lp1;
        rp1 <= rmem[right_addr_out];
        rp2 <= rp1;
    end
    assign left_pixel_in  = lp2;
    assign right_pixel_in = rp2;

    // Expected columns in raster order: centers y = 1..H-2, element k = row y-1+k.
    task automatic build_model();
        for (int i = 0; i < NCOL; i++) begin
            exp_x[i] = i % W;
            exp_y[i] = 1 + i / W;
            for (int k = 0; k < 3; k++) begin
                exp_l[i][k] = lmem[(exp_y[i]-1+k)*W + exp_x[i]];
                exp_r[i][k] = rmem[(exp_y[i]-1+k)*W + exp_x[i]];
            end
        end
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < W*H; i++) begin
            lmem[i] = 8'(16*(i/W) + (i%W));
            rmem[i] = 8'(16*(i/W) + (i%W));
        end
        build_model();
    endtask

    task automatic fill_random();
        for (int i = 0; i < W*H; i++) begin
            lmem[i] = 8'($urandom_range(0, 255));
            rmem[i] = 8'($urandom_range(0, 255));
        end
        build_model();
    endtask

    // mode 0: sad idle; mode 1: sad busy 11 cycles after each valid;
    // mode 2: sad busy 20 cycles after the 2nd valid. Cycle 0 = start sampled.
    task automatic scan_frame(input int mode, input bit noise);
        int idx, last_v, ready, bcnt, cyc;
        bit seen_done, exp_v, exp_d, exp_b;
        idx = 0; last_v = -100; ready = 4 + L; bcnt = 0; seen_done = 0;
        start_in = 1'b1;
        @(posedge clk_in); #1;
        start_in = 1'b0;
        sad_busy_in = 1'b0;
        for (cyc = 1; cyc <= 1500 && !seen_done; cyc++) begin
            @(negedge clk_in);
            exp_v = (idx < NCOL) && (cyc >= ready) && !sad_busy_in;
            exp_d = (idx == NCOL) && (cyc == last_v + 1);
            exp_b = !((idx == NCOL) && (cyc > last_v));
            vectors += 3;
            if (data_valid_out !== exp_v) begin
                miscompares++;
                $display("FAIL valid mode=%0d cyc=%0d got=%b want=%b", mode, cyc, data_valid_out, exp_v);
            end
            if (done_out !== exp_d) begin
                miscompares++;
                $display("FAIL done mode=%0d cyc=%0d got=%b want=%b", mode, cyc, done_out, exp_d);
            end
            if (busy_out !== exp_b) begin
                miscompares++;
                $display("FAIL busy mode=%0d cyc=%0d got=%b want=%b", mode, cyc, busy_out, exp_b);
            end
            if (mode == 2 && sad_busy_in && cyc >= ready && idx < NCOL) begin
                vectors++;
                if (hcount_out !== 11'(exp_x[idx]) || vcount_out !== 10'(exp_y[idx]) ||
                    left_data_out !== exp_l[idx] || right_data_out !== exp_r[idx]) begin
                    miscompares++;
                    $display("FAIL hold_stable cyc=%0d got x=%0d y=%0d l=%h r=%h want x=%0d y=%0d l=%h r=%h",
                             cyc, hcount_out, vcount_out, left_data_out, right_data_out,
                             exp_x[idx], exp_y[idx], exp_l[idx], exp_r[idx]);
                end
            end
            if (data_valid_out && idx < NCOL) begin
                vectors += 4;
                if (hcount_out !== 11'(exp_x[idx])) begin
                    miscompares++;
                    $display("FAIL hcount col=%0d got=%0d want=%0d", idx, hcount_out, exp_x[idx]);
                end
                if (vcount_out !== 10'(exp_y[idx])) begin
                    miscompares++;
                    $display("FAIL vcount col=%0d got=%0d want=%0d", idx, vcount_out, exp_y[idx]);
                end
                if (left_data_out !== exp_l[idx]) begin
                    miscompares++;
                    $display("FAIL left_col col=%0d got=%h want=%h", idx, left_data_out, exp_l[idx]);
                end
                if (right_data_out !== exp_r[idx]) begin
                    miscompares++;
                    $display("FAIL right_col col=%0d got=%h want=%h", idx, right_data_out, exp_r[idx]);
                end
                last_v = cyc;
                ready  = cyc + 1 + 3 + L;
                idx++;
            end
            if (done_out === 1'b1) begin
                seen_done = 1;
                if (noise) start_in = 1'b1;
            end
            @(posedge clk_in); #1;
            start_in = noise && !seen_done && (cyc == 19 || cyc == 44);
            case (mode)
                1: begin
                    if (last_v == cyc) bcnt = 11; else if (bcnt > 0) bcnt--;
                    sad_busy_in = (bcnt > 0);
                end
                2: begin
                    if (last_v == cyc && idx == 2) bcnt = 20; else if (bcnt > 0) bcnt--;
                    sad_busy_in = (bcnt > 0);
                end
                default: sad_busy_in = 1'b0;
            endcase
        end
        sad_busy_in = 1'b0;
        vectors += 2;
        if (!seen_done) begin
            miscompares++;
            $display("FAIL frame_timeout mode=%0d got=no_done want=done", mode);
        end
        if (idx != NCOL) begin
            miscompares++;
            $display("FAIL column_count mode=%0d got=%0d want=%0d", mode, idx, NCOL);
        end
        if (noise) begin
            for (int c = 0; c < 8; c++) begin
                @(negedge clk_in);
                vectors++;
                if (busy_out !== 1'b0 || data_valid_out !== 1'b0) begin
                    miscompares++;
                    $display("FAIL no_restart c=%0d got busy=%b valid=%b want 0 0", c, busy_out, data_valid_out);
                end
            end
            @(posedge clk_in); #1;
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        vectors++;
        if (left_addr_out !== '0 || right_addr_out !== '0 || left_data_out !== '0 ||
            right_data_out !== '0 || hcount_out !== '0 || vcount_out !== '0 ||
            data_valid_out !== 1'b0 || busy_out !== 1'b0 || done_out !== 1'b0) begin
            miscompares++;
            $display("FAIL %s got addr=%0d/%0d l=%h r=%h x=%0d y=%0d v=%b b=%b d=%b want all 0",
                     tag, left_addr_out, right_addr_out, left_data_out, right_data_out,
                     hcount_out, vcount_out, data_valid_out, busy_out, done_out);
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        check_zero_outputs("reset_state");
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_in);
            vectors++;
            if (busy_out !== 1'b0 || data_valid_out !== 1'b0 || left_addr_out !== '0) begin
                miscompares++;
                $display("FAIL idle_quiet c=%0d got busy=%b valid=%b addr=%0d want 0 0 0",
                         c, busy_out, data_valid_out, left_addr_out);
            end
        end
        @(posedge clk_in); #1;
    endtask

    task automatic test_full_frame();
        fill_ramp();
        scan_frame(0, 0);
    endtask

    task automatic test_backpressure();
        fill_random();
        scan_frame(2, 0);
    endtask

    task automatic test_sad_model();
        fill_random();
        scan_frame(1, 0);
    endtask

    task automatic test_reset_mid_frame();
        int seen;
        fill_random();
        seen = 0;
        start_in = 1'b1;
        @(posedge clk_in); #1;
        start_in = 1'b0;
        for (int c = 0; c < 300 && seen < 5; c++) begin
            @(negedge clk_in);
            if (data_valid_out === 1'b1) seen++;
            @(posedge clk_in); #1;
        end
        vectors++;
        if (seen != 5) begin
            miscompares++;
            $display("FAIL mid_reset_reach got=%0d want=5", seen);
        end
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        @(negedge clk_in);
        check_zero_outputs("mid_reset_state");
        @(posedge clk_in); #1;
        scan_frame(0, 0);
    endtask

    task automatic test_ignored_starts();
        fill_random();
        scan_frame(0, 1);
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_backpressure();
        test_sad_model();
        test_reset_mid_frame();
        test_ignored_starts();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
